nvram_arbiter: RTL and testbench

- Shares one single-port high-score NVRAM (EAROM shadow RAM) between two requesters:
  - the game CPU, a synchronous req/ack port;
  - the HPS ioctl channel, used for save-file download (load) and upload (save).
- Sits in the core top, between hps_io and the game module.
- Provides a one-entry HPS holding buffer, bounded-starvation priority, and a dirty flag that drives autosave.

---
 rtl/nvram_pkg.sv | 24 ++
 rtl/nvram_arbiter.sv | 136 +++++++++++++
 tb/tb_nvram_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/nvram_pkg.sv
// rtl/nvram_pkg.sv - shared types and defaults for the NVRAM arbiter
package nvram_pkg;

    localparam int NV_ADDR_W    = 6;
    localparam int NV_DATA_W    = 8;
    localparam int IOCTL_ADDR_W = 25;
    localparam logic [7:0] NV_INDEX_DEF = 8'd4;

    typedef enum logic [2:0] {
        IDLE,
        C_ACC,
        C_ACK,
        H_ACC,
        H_DONE
    } state_t;

    // One-entry HPS holding register; the full ioctl address is kept so range checks stay local
    typedef struct packed {
        logic [IOCTL_ADDR_W-1:0] addr;
        logic [NV_DATA_W-1:0]    data;
        logic                    is_wr;
    } hold_t;

endpackage

// File: rtl/nvram_arbiter.sv
// rtl/nvram_arbiter.sv - CPU / HPS ioctl arbiter for a shared single-port high-score NVRAM
module nvram_arbiter
    import nvram_pkg::*;
#(
    parameter int         ADDR_W   = NV_ADDR_W,
    parameter int         DATA_W   = NV_DATA_W,
    parameter logic [7:0] NV_INDEX = NV_INDEX_DEF,
    parameter int         STARVE   = 4
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_din,
    output logic [DATA_W-1:0]       cpu_dout,
    output logic                    cpu_ack,
    input  logic                    ioctl_download,
    input  logic                    ioctl_upload,
    input  logic [7:0]              ioctl_index,
    input  logic                    ioctl_wr,
    input  logic                    ioctl_rd,
    input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
    input  logic [DATA_W-1:0]       ioctl_dout,
    output logic [DATA_W-1:0]       ioctl_din,
    output logic                    ioctl_wait,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic                    ram_we,
    output logic [DATA_W-1:0]       ram_din,
    input  logic [DATA_W-1:0]       ram_dout,
    output logic                    dirty
);

    localparam int SW = $clog2(STARVE + 1);

    state_t          state;
    hold_t           hold_q;
    logic            pend;
    logic            up_nv_q;
    logic [SW-1:0]   starve_cnt;

    logic nv_sel, hps_wr, hps_rd, oor, hps_ready, starve_max, cpu_wr_done, up_fall;

    assign nv_sel      = (ioctl_index == NV_INDEX);
    assign hps_wr      = ioctl_wr & ioctl_download & nv_sel;
    assign hps_rd      = ioctl_rd & ioctl_upload & nv_sel;
    assign oor         = |hold_q.addr[IOCTL_ADDR_W-1:ADDR_W];
    assign hps_ready   = pend & ~oor;
    assign starve_max  = (starve_cnt == SW'(STARVE));
    assign cpu_wr_done = (state == C_ACC) & ram_we;
    assign up_fall     = up_nv_q & ~ioctl_upload;
    assign ioctl_wait  = pend;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold_q     <= '0;
            pend       <= 1'b0;
            up_nv_q    <= 1'b0;
            starve_cnt <= '0;
            cpu_ack    <= 1'b0;
            cpu_dout   <= '0;
            ioctl_din  <= '0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_din    <= '0;
            dirty      <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            up_nv_q <= ioctl_upload & nv_sel;

            // A CPU write landing in the same cycle as the upload end must keep the flag set
            if (cpu_wr_done) begin
                dirty <= 1'b1;
            end else if (up_fall) begin
                dirty <= 1'b0;
            end

            if (!pend) begin
                if (hps_wr | hps_rd) begin
                    pend         <= 1'b1;
                    hold_q.addr  <= ioctl_addr;
                    hold_q.data  <= ioctl_dout;
                    hold_q.is_wr <= hps_wr;
                end
            end else if (oor) begin
                pend <= 1'b0;
                if (!hold_q.is_wr) begin
                    ioctl_din <= '0;
                end
            end

            case (state)
                IDLE: begin
                    if (hps_ready && (!cpu_req || starve_max)) begin
                        state      <= H_ACC;
                        ram_addr   <= hold_q.addr[ADDR_W-1:0];
                        ram_we     <= hold_q.is_wr;
                        ram_din    <= hold_q.data;
                        starve_cnt <= '0;
                    end else if (cpu_req) begin
                        state    <= C_ACC;
                        ram_addr <= cpu_addr;
                        ram_we   <= cpu_we;
                        ram_din  <= cpu_din;
                        if (hps_ready && !starve_max) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end
                end
                C_ACC: begin
                    state  <= C_ACK;
                    ram_we <= 1'b0;
                end
                C_ACK: begin
                    state    <= IDLE;
                    cpu_ack  <= 1'b1;
                    cpu_dout <= ram_dout;
                end
                H_ACC: begin
                    state  <= H_DONE;
                    ram_we <= 1'b0;
                end
                H_DONE: begin
                    state <= IDLE;
                    pend  <= 1'b0;
                    if (!hold_q.is_wr) begin
                        ioctl_din <= ram_dout;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nvram_arbiter.sv
// tb/tb_nvram_arbiter.sv - directed self-checking bench for nvram_arbiter with a behavioural RAM
module tb_nvram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [5:0]  cpu_addr;
    logic [7:0]  cpu_din, cpu_dout;
    logic        cpu_ack;
    logic        ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_din;
    logic        ioctl_wait;
    logic [5:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_din, ram_dout;
    logic        dirty;

    logic [7:0]  mem [64];
    logic        mem_init;

    int checks = 0;
    int errors = 0;

    nvram_arbiter dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .dirty(dirty)
    );

    always #5 clk_sys = ~clk_sys;

    // Single-port RAM, read-first, one-cycle read latency
    always @(posedge clk_sys) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            ram_dout <= 8'h00;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_access(input logic we, input logic [5:0] a, input logic [7:0] d,
                              output int lat, output logic [7:0] dout);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
        lat = 0;
        do begin
            tick;
            lat++;
        end while (!cpu_ack && lat < 10);
        dout = cpu_dout;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic hps_strobe(input logic wr, input logic [24:0] a, input logic [7:0] d,
                              output int wt, output logic saw_we);
        ioctl_addr = a; ioctl_dout = d;
        if (wr) ioctl_wr = 1'b1; else ioctl_rd = 1'b1;
        tick;
        ioctl_wr = 1'b0; ioctl_rd = 1'b0;
        wt = 0; saw_we = 1'b0;
        while (ioctl_wait && wt < 20) begin
            wt++;
            if (ram_we) saw_we = 1'b1;
            tick;
        end
    endtask

    int          lat, wt, acks, n;
    logic        sw;
    logic [7:0]  dout;

    initial begin
        mem_init = 1'b1;
        reset_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0;
        ioctl_download = 0; ioctl_upload = 0; ioctl_index = 8'd4;
        ioctl_wr = 0; ioctl_rd = 0; ioctl_addr = 0; ioctl_dout = 0;
        repeat (3) tick;
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_dirty", dirty, 0);
        check("rst_ioctl_din", ioctl_din, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        check("rst_ram_addr", ram_addr, 0);
        mem_init = 1'b0;
        reset_n = 1'b1;
        tick;

        // CPU write then read back
        cpu_access(1'b1, 6'h03, 8'h5A, lat, dout);
        check("cpu_wr_lat", lat, 3);
        check("cpu_wr_dirty", dirty, 1);
        cpu_access(1'b0, 6'h03, 8'h00, lat, dout);
        check("cpu_rd_lat", lat, 3);
        check("cpu_rd_data", dout, 8'h5A);

        // Upload end with the NV index clears dirty
        ioctl_upload = 1'b1; tick; ioctl_upload = 1'b0; tick;
        check("dirty_clr", dirty, 0);

        // HPS download of four bytes, CPU idle
        ioctl_download = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hps_strobe(1'b1, 25'(i), 8'h11 + 8'(i), wt, sw);
            check("dl_wait_cycles", wt, 3);
            check("dl_ram_we", sw, 1);
        end
        ioctl_download = 1'b0;
        for (int i = 0; i < 4; i++) check("dl_mem", mem[i], 8'h11 + 8'(i));
        check("dl_dirty", dirty, 0);

        // HPS read pending against a CPU that never lets go
        ioctl_upload = 1'b1;
        ioctl_addr = 25'd2; ioctl_rd = 1'b1;
        tick;
        ioctl_rd = 1'b0;
        check("starve_wait_set", ioctl_wait, 1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h01;
        acks = 0; n = 0;
        while (ioctl_wait && n < 100) begin
            tick;
            n++;
            if (cpu_ack) begin
                acks++;
                check("starve_cpu_dout", cpu_dout, 8'h12);
            end
        end
        check("starve_acks", acks, 4);
        check("starve_ioctl_din", ioctl_din, 8'h13);
        lat = 0;
        do begin tick; lat++; end while (!cpu_ack && lat < 10);
        check("starve_cpu_resume", lat, 3);
        check("starve_cpu_resume_dout", cpu_dout, 8'h12);
        cpu_req = 1'b0;
        tick;

        // Set beats clear when a CPU write coincides with the upload end
        cpu_access(1'b1, 6'h05, 8'h77, lat, dout);
        check("dirty_set2", dirty, 1);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h06; cpu_din = 8'h66;
        tick;
        ioctl_upload = 1'b0;
        tick;
        check("dirty_set_wins", dirty, 1);
        tick;
        check("dirty_wr_ack", cpu_ack, 1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick;
        check("dirty_wr_mem", mem[6], 8'h66);
        ioctl_index = 8'd3; ioctl_upload = 1'b1; tick; ioctl_upload = 1'b0; tick;
        check("dirty_other_index", dirty, 1);
        ioctl_index = 8'd4; ioctl_upload = 1'b1; tick; ioctl_upload = 1'b0; tick;
        check("dirty_clr2", dirty, 0);

        // Out-of-range HPS accesses
        ioctl_download = 1'b1;
        hps_strobe(1'b1, 25'h40, 8'hEE, wt, sw);
        check("oor_wr_wait", wt, 1);
        check("oor_wr_no_we", sw, 0);
        check("oor_wr_mem0", mem[0], 8'h11);
        ioctl_download = 1'b0;
        ioctl_upload = 1'b1;
        hps_strobe(1'b0, 25'd3, 8'h00, wt, sw);
        check("up_rd_din", ioctl_din, 8'h14);
        hps_strobe(1'b0, 25'h40, 8'h00, wt, sw);
        check("oor_rd_wait", wt, 1);
        check("oor_rd_din", ioctl_din, 8'h00);
        hps_strobe(1'b0, 25'd3, 8'h00, wt, sw);
        ioctl_upload = 1'b0;
        tick;

        // Reset in the middle of an HPS access
        cpu_access(1'b1, 6'h08, 8'hA5, lat, dout);
        check("pre_rst_dirty", dirty, 1);
        ioctl_download = 1'b1;
        ioctl_addr = 25'd7; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
        tick;
        ioctl_wr = 1'b0;
        tick;
        check("pre_rst_h_acc_we", ram_we, 1);
        reset_n = 1'b0;
        tick;
        check("mid_rst_cpu_ack", cpu_ack, 0);
        check("mid_rst_ram_we", ram_we, 0);
        check("mid_rst_wait", ioctl_wait, 0);
        check("mid_rst_dirty", dirty, 0);
        check("mid_rst_ioctl_din", ioctl_din, 0);
        check("mid_rst_cpu_dout", cpu_dout, 0);
        check("mid_rst_ram_addr", ram_addr, 0);
        ioctl_download = 1'b0;
        reset_n = 1'b1;
        tick;
        check("post_rst_wait", ioctl_wait, 0);
        cpu_access(1'b0, 6'h03, 8'h00, lat, dout);
        check("post_rst_lat", lat, 3);
        check("post_rst_dout", dout, 8'h14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
